// File: rtl/asteroids_pkg.sv
// Shared ship life-cycle types and default frame counts for the respawn controller.
package asteroids_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ALIVE      = 3'd1,
        EXPLODE    = 3'd2,
        WAIT_CLEAR = 3'd3,
        BLINK      = 3'd4,
        GAME_OVER  = 3'd5
    } ship_state_t;

    localparam int EXPLODE_FRAMES_DEF = 60;
    localparam int INVULN_FRAMES_DEF  = 120;
    localparam int BLINK_PERIOD_DEF   = 4;
    localparam int CLEAR_TIMEOUT_DEF  = 180;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ship_respawn_ctrl_frame_timer.sv
// Frame down-counter: load wins over tick, stops at zero, done on the tick that ends the count.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] cnt;

    // A count of zero expires on the next tick just like a count of one.
    assign done = tick && (cnt <= W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/ship_respawn_ctrl.sv
// Ship life-cycle FSM: die qualification, explode, wait for clear spawn zone, invulnerable blink.
// Build option SHIP_RESPAWN_BLINK_EN: blink the ship draw mask while invulnerable.
//
// state      | meaning
// IDLE       | opening screen, ship drawn, invulnerable
// ALIVE      | ship in play, collisions qualify a death
// EXPLODE    | ship hidden, explosion shown for EXPLODE_FRAMES
// WAIT_CLEAR | ship recentred but hidden until spawn zone clear or timeout
// BLINK      | invulnerable for INVULN_FRAMES, mask optionally blinking
// GAME_OVER  | terminal until reset
module ship_respawn_ctrl
    import asteroids_pkg::*;
#(
    parameter int EXPLODE_FRAMES = EXPLODE_FRAMES_DEF,
    parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF,
    parameter int BLINK_PERIOD   = BLINK_PERIOD_DEF,
    parameter int CLEAR_TIMEOUT  = CLEAR_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_pulse,
    input  logic       start_done,
    input  logic       collision,
    input  logic       asteroid_in_zone,
    input  logic       game_over,
    output logic       die_pulse,
    output logic       ship_respawn,
    output logic       ship_draw_mask,
    output logic       exploding,
    output logic       invulnerable,
    output logic [2:0] state
);

    localparam int TW = $clog2(max_of4(EXPLODE_FRAMES, INVULN_FRAMES, BLINK_PERIOD, CLEAR_TIMEOUT) + 1);

    ship_state_t    state_q, state_nxt;
    logic           die_nxt, respawn_nxt, mask_nxt;
    logic           timer_load, timer_done;
    logic [TW-1:0]  timer_val;
    logic           zone_hit, armed;
    logic           blink_mask;

    frame_timer #(.W(TW)) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (vsync_pulse),
        .done     (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        die_nxt     = 1'b0;
        respawn_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_done) state_nxt = ALIVE;
            end
            ALIVE: begin
                if (game_over) begin
                    state_nxt = GAME_OVER;
                end else if (collision) begin
                    state_nxt = EXPLODE;
                    die_nxt   = 1'b1;
                end
            end
            EXPLODE: begin
                if (timer_done) begin
                    if (game_over) begin
                        state_nxt = GAME_OVER;
                    end else begin
                        state_nxt   = WAIT_CLEAR;
                        respawn_nxt = 1'b1;
                    end
                end
            end
            WAIT_CLEAR: begin
                // The arming vsync only closes the partial frame seen on entry.
                if (game_over) begin
                    state_nxt = GAME_OVER;
                end else if (vsync_pulse && armed &&
                             (!(zone_hit || asteroid_in_zone) || timer_done)) begin
                    state_nxt = BLINK;
                end
            end
            BLINK: begin
                if (game_over) begin
                    state_nxt = GAME_OVER;
                end else if (timer_done) begin
                    state_nxt = ALIVE;
                end
            end
            GAME_OVER: state_nxt = GAME_OVER;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timer_load = (state_nxt != state_q);
        case (state_nxt)
            EXPLODE:    timer_val = TW'(EXPLODE_FRAMES);
            WAIT_CLEAR: timer_val = TW'(CLEAR_TIMEOUT);
            BLINK:      timer_val = TW'(INVULN_FRAMES);
            default:    timer_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone_hit <= 1'b0;
            armed    <= 1'b0;
        end else if ((state_q == WAIT_CLEAR) && (state_nxt == WAIT_CLEAR)) begin
            armed    <= armed | vsync_pulse;
            zone_hit <= vsync_pulse ? 1'b0 : (zone_hit | asteroid_in_zone);
        end else begin
            zone_hit <= 1'b0;
            armed    <= 1'b0;
        end
    end

`ifdef SHIP_RESPAWN_BLINK_EN
    localparam int BW = $clog2(BLINK_PERIOD) + 1;

    logic [BW-1:0] blink_cnt, blink_cnt_nxt;

    always_comb begin
        blink_cnt_nxt = blink_cnt;
        if ((state_nxt == BLINK) && (state_q != BLINK)) begin
            blink_cnt_nxt = '0;
        end else if ((state_q == BLINK) && vsync_pulse) begin
            blink_cnt_nxt = blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
        end
    end

    assign blink_mask = ~blink_cnt_nxt[BW-1];
`else
    assign blink_mask = 1'b1;
`endif

    always_comb begin
        case (state_nxt)
            IDLE, ALIVE: mask_nxt = 1'b1;
            BLINK:       mask_nxt = blink_mask;
            default:     mask_nxt = 1'b0;
        endcase
    end

    // Outputs follow the next state so they line up with the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            die_pulse      <= 1'b0;
            ship_respawn   <= 1'b0;
            ship_draw_mask <= 1'b1;
            exploding      <= 1'b0;
            invulnerable   <= 1'b1;
        end else begin
            die_pulse      <= die_nxt;
            ship_respawn   <= respawn_nxt;
            ship_draw_mask <= mask_nxt;
            exploding      <= (state_nxt == EXPLODE);
            invulnerable   <= (state_nxt != ALIVE);
        end
    end

    assign state = state_q;

endmodule
